// File: rtl/register_file_scoreboard.sv
// Register file with write-to-read forwarding and a per-register
// pending-write scoreboard that produces the issue stall.
module register_file_scoreboard #(
   parameter int DATA_LENGTH = 32,
   parameter int REGS_QTY = 32,
   parameter logic [DATA_LENGTH-1:0] SP_RST_VAL = 32'h7fffeffc,
   parameter logic [DATA_LENGTH-1:0] GP_RST_VAL = 32'h10008000,
   parameter int BYPASS = 1,
   localparam int ADDR_LENGTH = $clog2(REGS_QTY)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [ADDR_LENGTH-1:0] wr_addr,
   input  logic [DATA_LENGTH-1:0] wr_data,
   input  logic [ADDR_LENGTH-1:0] rd_addr_a,
   input  logic [ADDR_LENGTH-1:0] rd_addr_b,
   output logic [DATA_LENGTH-1:0] rd_data_a,
   output logic [DATA_LENGTH-1:0] rd_data_b,
   input  logic                   iss_valid,
   input  logic [ADDR_LENGTH-1:0] iss_rd,
   input  logic [ADDR_LENGTH-1:0] iss_rs1,
   input  logic [ADDR_LENGTH-1:0] iss_rs2,
   input  logic                   iss_use_rd,
   input  logic                   iss_use_rs1,
   input  logic                   iss_use_rs2,
   output logic                   stall,
   output logic [REGS_QTY-1:0]    busy
);

   logic [DATA_LENGTH-1:0] regs_q [REGS_QTY];
   logic [DATA_LENGTH-1:0] regs_d [REGS_QTY];
   logic [REGS_QTY-1:0]    busy_q;
   logic [REGS_QTY-1:0]    busy_d;
   logic [REGS_QTY-1:0]    wr_hit;
   logic [REGS_QTY-1:0]    hazard_vec;
   logic                   wr_ok;
   logic                   haz_rs1;
   logic                   haz_rs2;
   logic                   haz_rd;
   logic                   iss_accept;

   function automatic logic in_range(input logic [ADDR_LENGTH-1:0] a);
      return int'(a) < REGS_QTY;
   endfunction

   function automatic logic [DATA_LENGTH-1:0] read_port(
      input logic [ADDR_LENGTH-1:0] a,
      input logic [DATA_LENGTH-1:0] stored
   );
      logic [DATA_LENGTH-1:0] v;
      v = stored;
      if (a == '0 || !in_range(a))
         v = '0;
      else if (BYPASS != 0 && wr_en && wr_addr == a)
         v = wr_data;
      return v;
   endfunction

   assign wr_ok = wr_en && wr_addr != '0 && in_range(wr_addr);

   always_comb begin
      wr_hit = '0;
      for (int r = 1; r < REGS_QTY; r++)
         wr_hit[r] = wr_en && (int'(wr_addr) == r);
      hazard_vec = busy_q & ~((BYPASS != 0) ? wr_hit : '0);
   end

   always_comb begin
      haz_rs1 = 1'b0;
      haz_rs2 = 1'b0;
      haz_rd  = 1'b0;
      if (iss_use_rs1 && in_range(iss_rs1))
         haz_rs1 = hazard_vec[iss_rs1];
      if (iss_use_rs2 && in_range(iss_rs2))
         haz_rs2 = hazard_vec[iss_rs2];
      // WAW is released by a same-cycle write whether or not bypass exists
      if (iss_use_rd && iss_rd != '0 && in_range(iss_rd))
         haz_rd = busy_q[iss_rd] && !wr_hit[iss_rd];
      stall      = iss_valid && (haz_rs1 || haz_rs2 || haz_rd);
      iss_accept = iss_valid && !stall;
   end

   always_comb begin
      regs_d = regs_q;
      if (wr_ok)
         regs_d[wr_addr] = wr_data;
   end

   always_comb begin
      busy_d = busy_q;
      if (wr_en && in_range(wr_addr))
         busy_d[wr_addr] = 1'b0;
      // set after clear so a same-edge reissue keeps the register pending
      if (iss_accept && iss_use_rd && in_range(iss_rd))
         busy_d[iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REGS_QTY; i++)
            regs_q[i] <= '0;
         regs_q[2] <= SP_RST_VAL;
         regs_q[3] <= GP_RST_VAL;
         busy_q    <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign rd_data_a = read_port(rd_addr_a, in_range(rd_addr_a) ? regs_q[rd_addr_a] : '0);
   assign rd_data_b = read_port(rd_addr_b, in_range(rd_addr_b) ? regs_q[rd_addr_b] : '0);
   assign busy      = busy_q;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench: stimulus queues expectations per cycle, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_register_file_scoreboard;

   localparam logic [31:0] SP = 32'h7fffeffc;
   localparam logic [31:0] GP = 32'h10008000;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr_a, rd_addr_b;
   logic [31:0] rd_data_a, rd_data_b;
   logic        iss_valid;
   logic [4:0]  iss_rd, iss_rs1, iss_rs2;
   logic        iss_use_rd, iss_use_rs1, iss_use_rs2;
   logic        stall;
   logic [31:0] busy;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   register_file_scoreboard dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_use_rd(iss_use_rd), .iss_use_rs1(iss_use_rs1),
      .iss_use_rs2(iss_use_rs2),
      .stall(stall), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_v(input int kind, input logic [31:0] val, input string name);
      exp_t e;
      e.cyc  = cyc;
      e.kind = kind;
      e.val  = val;
      e.name = name;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         logic [31:0] act;
         e = q.pop_front();
         case (e.kind)
            0: act = rd_data_a;
            1: act = rd_data_b;
            2: act = {31'd0, stall};
            default: act = busy;
         endcase
         n_cmp++;
         if (e.cyc != cyc || act !== e.val) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d/%0d)",
                     e.name, act, e.val, cyc, e.cyc);
         end
      end
   end

   initial begin
      rst = 1'b0;
      wr_en = 0; wr_addr = 0; wr_data = 0;
      rd_addr_a = 0; rd_addr_b = 0;
      iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
      iss_use_rd = 0; iss_use_rs1 = 0; iss_use_rs2 = 0;

      step();
      rd_addr_a = 2; rd_addr_b = 3;
      expect_v(0, SP, "rst_sp");
      expect_v(1, GP, "rst_gp");
      expect_v(3, 0, "rst_busy");

      step();
      rst = 1'b1;
      expect_v(0, SP, "sp_after_rst");
      expect_v(1, GP, "gp_after_rst");

      step();
      rd_addr_a = 0;
      expect_v(0, 0, "x0_read");

      step();
      wr_en = 1; wr_addr = 0; wr_data = 32'hdeadbeef;
      expect_v(0, 0, "x0_write_bypass");

      step();
      wr_addr = 5; wr_data = 32'h12345678;
      rd_addr_a = 5; rd_addr_b = 0;
      expect_v(0, 32'h12345678, "bypass_x5");
      expect_v(1, 0, "x0_after_write");

      step();
      wr_en = 0;
      expect_v(0, 32'h12345678, "stored_x5");
      expect_v(3, 0, "busy_nonbusy_write");

      step();
      iss_valid = 1; iss_rd = 7; iss_use_rd = 1;
      expect_v(2, 0, "issue_rd7");

      step();
      iss_use_rd = 0; iss_use_rs1 = 1; iss_rs1 = 7;
      rd_addr_a = 7;
      expect_v(2, 1, "raw_stall_rs1");
      expect_v(3, 32'h0000_0080, "busy7_set");
      expect_v(0, 0, "x7_stored_zero");

      step();
      wr_en = 1; wr_addr = 7; wr_data = 32'ha5a5a5a5;
      expect_v(2, 0, "raw_release_wb");
      expect_v(0, 32'ha5a5a5a5, "x7_forward");
      expect_v(3, 32'h0000_0080, "busy7_still");

      step();
      wr_en = 0; iss_valid = 0; iss_use_rs1 = 0;
      expect_v(3, 0, "busy7_cleared");
      expect_v(0, 32'ha5a5a5a5, "x7_stored");

      step();
      iss_valid = 1; iss_rd = 9; iss_use_rd = 1;
      expect_v(2, 0, "issue_rd9");

      step();
      wr_en = 1; wr_addr = 9; wr_data = 32'h1111;
      expect_v(3, 32'h0000_0200, "busy9_set");
      expect_v(2, 0, "waw_release_wb9");

      step();
      wr_en = 0; iss_valid = 0; iss_use_rd = 0;
      rd_addr_a = 9;
      expect_v(3, 32'h0000_0200, "busy9_set_wins");
      expect_v(0, 32'h1111, "x9_stored");

      step();
      wr_en = 1; wr_addr = 9; wr_data = 32'h2222;

      step();
      wr_en = 0;
      iss_valid = 1; iss_rd = 4; iss_use_rd = 1;
      expect_v(3, 0, "busy9_cleared");
      expect_v(2, 0, "issue_rd4");

      step();
      expect_v(3, 32'h0000_0010, "busy4_set");
      expect_v(2, 1, "waw_stall_rd4");

      step();
      iss_use_rd = 0; iss_use_rs2 = 1; iss_rs2 = 4;
      expect_v(2, 1, "raw_stall_rs2");

      step();
      iss_use_rs2 = 0; iss_use_rd = 1; iss_rd = 0;
      expect_v(2, 0, "rd0_no_stall");

      step();
      iss_valid = 0; iss_use_rd = 0;
      wr_en = 1; wr_addr = 4; wr_data = 32'h4444;
      expect_v(3, 32'h0000_0010, "busy0_zero");

      step();
      wr_en = 0;
      iss_valid = 1; iss_use_rd = 1; iss_rd = 6;
      expect_v(3, 0, "busy4_cleared");

      step();
      iss_rd = 8;
      expect_v(3, 32'h0000_0040, "busy6_set");

      step();
      iss_valid = 0; iss_use_rd = 0;
      expect_v(3, 32'h0000_0140, "busy6_8_set");

      step();
      rst = 1'b0;
      rd_addr_a = 2; rd_addr_b = 5;
      iss_valid = 1; iss_use_rs1 = 1; iss_rs1 = 6;
      expect_v(3, 0, "async_rst_busy");
      expect_v(0, SP, "async_rst_sp");
      expect_v(1, 0, "async_rst_x5");
      expect_v(2, 0, "rst_no_stall");

      step();
      rst = 1'b1; iss_valid = 0; iss_use_rs1 = 0;
      step();
      step();

      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/register_file_scoreboard.md
REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_LENGTH, default 32, meaning width of each register.
REQ-002 The block SHALL have parameter REGS_QTY, default 32, meaning number of architectural registers; ADDR_LENGTH = $clog2(REGS_QTY).
REQ-003 The block SHALL have parameter SP_RST_VAL, default 32'h7fffeffc, meaning reset value of register 2.
REQ-004 The block SHALL have parameter GP_RST_VAL, default 32'h10008000, meaning reset value of register 3.
REQ-005 The block SHALL have parameter BYPASS, default 1, meaning 1 enables write-to-read forwarding and same-cycle hazard release.
REQ-006 The block SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1, meaning reset, asynchronous, active-low.
REQ-008 The block SHALL have port wr_en, input, 1, meaning writeback strobe.
REQ-009 The block SHALL have port wr_addr, input, ADDR_LENGTH, meaning writeback destination.
REQ-010 The block SHALL have port wr_data, input, DATA_LENGTH, meaning writeback value.
REQ-011 The block SHALL have ports rd_addr_a and rd_addr_b, input, ADDR_LENGTH each, meaning read addresses.
REQ-012 The block SHALL have ports rd_data_a and rd_data_b, output, DATA_LENGTH each, meaning combinational read data.
REQ-013 The block SHALL have port iss_valid, input, 1, meaning an instruction requests issue.
REQ-014 The block SHALL have ports iss_rd, iss_rs1, iss_rs2, input, ADDR_LENGTH each, meaning issuing instruction's destination and sources.
REQ-015 The block SHALL have ports iss_use_rd, iss_use_rs1, iss_use_rs2, input, 1 each, meaning corresponding field is valid.
REQ-016 The block SHALL have port stall, output, 1, meaning issue refused this cycle.
REQ-017 The block SHALL have port busy, output, REGS_QTY, meaning per-register pending-write flags.

Function
REQ-018 Register 0 SHALL always read 0; writes to it SHALL be ignored and busy[0] SHALL be constant 0.
REQ-019 On rising clk with wr_en=1 and wr_addr!=0, register[wr_addr] SHALL take wr_data; wr_addr >= REGS_QTY SHALL be ignored.
REQ-020 Reads SHALL be combinational; with BYPASS=1, wr_en=1 and rd_addr==wr_addr!=0, rd_data SHALL equal wr_data in the same cycle; with BYPASS=0, the stored value.
REQ-021 hazard_src(r) SHALL be busy[r] && !(BYPASS && wr_en && wr_addr==r), for r!=0.
REQ-022 stall SHALL be iss_valid && ((iss_use_rs1 && hazard_src(iss_rs1)) || (iss_use_rs2 && hazard_src(iss_rs2)) || (iss_use_rd && iss_rd!=0 && busy[iss_rd] && !(wr_en && wr_addr==iss_rd))).
REQ-023 Issue SHALL be accepted when iss_valid && !stall; if iss_use_rd and iss_rd!=0, busy[iss_rd] SHALL be set at the next edge.
REQ-024 A write with wr_en=1 SHALL clear busy[wr_addr] at the next edge.
REQ-025 Same-edge clear of register r and accepted issue setting r SHALL leave busy[r]=1 (set wins).
REQ-026 A write to a non-busy register SHALL update data and leave busy unchanged (0).
REQ-027 stall and rd_data SHALL be combinational; busy SHALL be registered, one-cycle latency from issue/writeback.

Reset
REQ-028 While rst=0, all registers SHALL be 0 except register 2 = SP_RST_VAL and register 3 = GP_RST_VAL, asynchronously.
REQ-029 While rst=0, busy SHALL be all 0; stall SHALL follow REQ-022 with busy=0.
REQ-030 Reset asserted mid-operation SHALL discard all pending busy flags and register contents immediately.

Verification
REQ-031 Release reset, read rd_addr_a=2, rd_addr_b=3 -> 32'h7fffeffc, 32'h10008000; rd_addr_a=0 -> 0.
REQ-032 Write 0 with 32'hdeadbeef, read 0 -> 0; write 5 with 32'h12345678, same cycle read 5 -> 32'h12345678 (BYPASS=1), next cycle still 32'h12345678.
REQ-033 Issue rd=7 (accepted), next cycle issue rs1=7 without writeback -> stall=1, busy[7]=1; same cycle wr_en, wr_addr=7 -> stall=0 and rd_data of 7 = wr_data.
REQ-034 busy[9]=1, same edge: writeback to 9 and accepted issue rd=9 (wr_en with wr_addr=9 present) -> busy[9]=1 after edge.
REQ-035 busy[4]=1, issue rd=4 without writeback -> stall=1 (WAW); rd=0 with iss_use_rd=1 -> never stalls, busy[0]=0.
REQ-036 Set busy on 6 and 8, assert rst=0 between edges -> busy=0 and register 2 = 32'h7fffeffc immediately, no clock required.
